// File: rtl/byte_packer_pkg.sv
// Shared types and lane helpers for the byte-to-word write packer.
package byte_packer_pkg;

  // Word address width carried through the packed-word FIFO.
  parameter int unsigned WORD_ADDR_W = 24;

  // One packed word write: word address, big-endian lane data, lane enables.
  typedef struct packed {
    logic [WORD_ADDR_W-1:0] addr;
    logic [15:0]            data;
    logic [1:0]             be;
  } packed_word_t;

  // Assembly register occupancy.
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } assembly_state_t;

  // Lane enable for a byte: even byte (lane 0) is be[1], odd byte is be[0].
  function automatic logic [1:0] lane_mask(input logic lane);
    if (lane) begin
      return 2'b01;
    end else begin
      return 2'b10;
    end
  endfunction

  // Replace one lane of a word; even byte lives in [15:8], odd byte in [7:0].
  function automatic logic [15:0] place_byte(input logic [15:0] word,
                                             input logic        lane,
                                             input logic [7:0]  value);
    if (lane) begin
      return {word[15:8], value};
    end else begin
      return {value, word[7:0]};
    end
  endfunction

endpackage

// File: rtl/packed_word_fifo.sv
// Show-ahead FIFO of packed words. A push while full is accepted only when a
// pop happens on the same edge; otherwise it is dropped.
module packed_word_fifo
  import byte_packer_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  packed_word_t     push_word,
  input  logic             pop,
  output packed_word_t     head,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  packed_word_t     mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             pop_ok_s;
  logic             push_ok_s;

  assign empty = (count_r == {CNT_W{1'b0}});
  assign full  = (count_r == CNT_W'(DEPTH));
  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

  // Qualify push/pop: pop needs data, push needs room or a simultaneous pop.
  always_comb begin
    pop_ok_s  = pop && !empty;
    push_ok_s = push && (!full || pop_ok_s);
  end

  // Storage array; data only, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= push_word;
    end
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/byte_write_packer.sv
// Packs a one-byte-per-cycle write stream into 16-bit word writes with byte
// enables and queues them for a req/ack memory port.
module byte_write_packer
  import byte_packer_pkg::*;
#(
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned FLUSH_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [31:0]       byte_address,
  input  logic [7:0]        byte_data,
  input  logic              byte_wr,
  output logic [ADDR_W-1:0] mem_address,
  output logic [15:0]       mem_data,
  output logic [1:0]        mem_be,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned FIFO_CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [7:0]  FLUSH_LAST = 8'(FLUSH_CYCLES - 1);

  assembly_state_t          state_r;
  logic [WORD_ADDR_W-1:0]   asm_addr_r;
  logic [15:0]              asm_data_r;
  logic [1:0]               asm_be_r;
  logic [7:0]               idle_r;
  logic                     overflow_r;

  logic [WORD_ADDR_W-1:0]   in_addr_s;
  logic                     lane_s;
  logic                     same_word_s;
  logic                     same_lane_s;
  logic                     flush_due_s;
  logic                     push_s;
  logic                     pop_s;
  packed_word_t             held_word_s;
  packed_word_t             push_word_s;
  packed_word_t             head_s;
  logic                     fifo_full_s;
  logic                     fifo_empty_s;
  logic [FIFO_CNT_W-1:0]    fifo_count_s;
  logic                     unused_addr_s;

  assign in_addr_s     = byte_address[WORD_ADDR_W:1];
  assign lane_s        = byte_address[0];
  assign unused_addr_s = ^byte_address[31:WORD_ADDR_W+1];

  assign mem_req  = !fifo_empty_s;
  assign pop_s    = !fifo_empty_s && mem_ack;
  assign busy     = (state_r == HOLD) || (fifo_count_s != {FIFO_CNT_W{1'b0}});
  assign overflow = overflow_r;

  // Decode the incoming byte against the held word.
  always_comb begin
    same_word_s      = (in_addr_s == asm_addr_r);
    same_lane_s      = |(asm_be_r & lane_mask(lane_s));
    flush_due_s      = (idle_r == FLUSH_LAST);
    held_word_s.addr = asm_addr_r;
    held_word_s.data = asm_data_r;
    held_word_s.be   = asm_be_r;
  end

  // Decide whether this edge pushes a word, and which one. A write always
  // wins over an idle flush on the same edge.
  always_comb begin
    push_s      = 1'b0;
    push_word_s = held_word_s;
    case (state_r)
      EMPTY: begin
        push_s = 1'b0;
      end
      HOLD: begin
        if (byte_wr) begin
          if (same_word_s) begin
            if (same_lane_s) begin
              push_s = 1'b0;
            end else begin
              push_s           = 1'b1;
              push_word_s.data = place_byte(asm_data_r, lane_s, byte_data);
              push_word_s.be   = 2'b11;
            end
          end else begin
            push_s = 1'b1;
          end
        end else begin
          if (flush_due_s) begin
            push_s = 1'b1;
          end else begin
            push_s = 1'b0;
          end
        end
      end
      default: begin
        push_s = 1'b0;
      end
    endcase
  end

  // Assembly state machine, idle counter and sticky overflow flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= EMPTY;
      asm_addr_r <= {WORD_ADDR_W{1'b0}};
      asm_data_r <= 16'h0000;
      asm_be_r   <= 2'b00;
      idle_r     <= 8'd0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s && fifo_full_s && !pop_s) begin
        overflow_r <= 1'b1;
      end
      case (state_r)
        EMPTY: begin
          if (byte_wr) begin
            state_r    <= HOLD;
            asm_addr_r <= in_addr_s;
            asm_data_r <= place_byte(16'h0000, lane_s, byte_data);
            asm_be_r   <= lane_mask(lane_s);
            idle_r     <= 8'd0;
          end
        end
        HOLD: begin
          if (byte_wr) begin
            if (same_word_s && same_lane_s) begin
              asm_data_r <= place_byte(asm_data_r, lane_s, byte_data);
              idle_r     <= 8'd0;
            end else if (same_word_s) begin
              state_r <= EMPTY;
            end else begin
              asm_addr_r <= in_addr_s;
              asm_data_r <= place_byte(16'h0000, lane_s, byte_data);
              asm_be_r   <= lane_mask(lane_s);
              idle_r     <= 8'd0;
            end
          end else if (flush_due_s) begin
            state_r <= EMPTY;
          end else begin
            idle_r <= idle_r + 8'd1;
          end
        end
        default: begin
          state_r <= EMPTY;
        end
      endcase
    end
  end

  // Present the FIFO head; fields read as zero while nothing is presented.
  always_comb begin
    if (fifo_empty_s) begin
      mem_address = {ADDR_W{1'b0}};
      mem_data    = 16'h0000;
      mem_be      = 2'b00;
    end else begin
      mem_address = ADDR_W'(head_s.addr);
      mem_data    = head_s.data;
      mem_be      = head_s.be;
    end
  end

  packed_word_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (push_s),
    .push_word (push_word_s),
    .pop       (pop_s),
    .head      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

endmodule

// File: tb/tb_byte_write_packer.sv
// Self-checking bench for byte_write_packer: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_byte_write_packer;

  localparam int DEPTH = 4;
  localparam int FLUSH = 4;

  typedef struct {
    logic [23:0] addr;
    logic [15:0] data;
    logic [1:0]  be;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] byte_address;
  logic [7:0]  byte_data;
  logic        byte_wr;
  logic [23:0] mem_address;
  logic [15:0] mem_data;
  logic [1:0]  mem_be;
  logic        mem_req;
  logic        mem_ack;
  logic        busy;
  logic        overflow;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  byte_write_packer #(
    .ADDR_W       (24),
    .FIFO_DEPTH   (DEPTH),
    .FLUSH_CYCLES (FLUSH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .byte_address (byte_address),
    .byte_data    (byte_data),
    .byte_wr      (byte_wr),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_be       (mem_be),
    .mem_req      (mem_req),
    .mem_ack      (mem_ack),
    .busy         (busy),
    .overflow     (overflow)
  );

  // Reference model: the partial word as two optional bytes plus a queue of
  // words waiting for the memory.
  logic        m_hold;
  logic [23:0] m_addr;
  logic [7:0]  m_even, m_odd;
  logic        m_has_even, m_has_odd;
  int          m_idle;
  logic        m_ovf;
  exp_t        m_q[$];

  function automatic void m_reset();
    m_hold = 1'b0; m_addr = 24'h0; m_even = 8'h00; m_odd = 8'h00;
    m_has_even = 1'b0; m_has_odd = 1'b0; m_idle = 0; m_ovf = 1'b0;
    m_q.delete();
  endfunction

  function automatic exp_t m_held();
    exp_t w;
    w.addr = m_addr;
    w.data = {m_even, m_odd};
    w.be   = {m_has_even, m_has_odd};
    return w;
  endfunction

  function automatic void m_emit(input exp_t w);
    if (m_q.size() >= DEPTH) m_ovf = 1'b1;
    else m_q.push_back(w);
  endfunction

  function automatic void m_load(input logic [23:0] wa, input logic odd, input logic [7:0] d);
    m_hold = 1'b1; m_addr = wa; m_idle = 0;
    m_even = odd ? 8'h00 : d;  m_has_even = !odd;
    m_odd  = odd ? d : 8'h00;  m_has_odd  = odd;
  endfunction

  function automatic void m_step(input logic wr, input logic [31:0] a, input logic [7:0] d, input logic ack);
    logic [23:0] wa;
    logic        odd;
    wa  = a[24:1];
    odd = a[0];
    if (ack && m_q.size() != 0) void'(m_q.pop_front());
    if (wr) begin
      if (!m_hold) m_load(wa, odd, d);
      else if (wa != m_addr) begin
        m_emit(m_held());
        m_load(wa, odd, d);
      end else if ((odd && m_has_odd) || (!odd && m_has_even)) begin
        if (odd) m_odd = d; else m_even = d;
        m_idle = 0;
      end else begin
        if (odd) begin m_odd = d; m_has_odd = 1'b1; end
        else begin m_even = d; m_has_even = 1'b1; end
        m_emit(m_held());
        m_hold = 1'b0;
      end
    end else if (m_hold) begin
      m_idle++;
      if (m_idle == FLUSH) begin
        m_emit(m_held());
        m_hold = 1'b0;
      end
    end
  endfunction

  // Apply one cycle of inputs (from a falling edge) and return at the next falling edge.
  task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d, input logic ack);
    byte_wr = wr; byte_address = a; byte_data = d; mem_ack = ack;
    m_step(wr, a, d, ack);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; byte_wr = 1'b0; byte_address = 32'h0; byte_data = 8'h00; mem_ack = 1'b0;
    m_reset();
    repeat (2) @(negedge clk);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", mem_req); end
    n_cmp++; if (mem_address !== 24'h0) begin n_err++; $display("FAIL reset_addr: got %h expected 0", mem_address); end
    n_cmp++; if (mem_data !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h expected 0", mem_data); end
    n_cmp++; if (mem_be !== 2'b00) begin n_err++; $display("FAIL reset_be: got %b expected 00", mem_be); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    reset_n = 1'b1;
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_ack_ignored: got %b expected 0", mem_req); end
  endtask

  task automatic test_pair();
    drive(1'b1, 32'h100, 8'hAA, 1'b1);
    n_cmp++; if (mem_req !== 1'b0 || busy !== 1'b1) begin n_err++; $display("FAIL pair_first: got req=%b busy=%b expected req=0 busy=1", mem_req, busy); end
    drive(1'b1, 32'h101, 8'hBB, 1'b1);
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL pair_req: got %b expected 1", mem_req); end
    n_cmp++; if (mem_address !== 24'h80) begin n_err++; $display("FAIL pair_addr: got %h expected 000080", mem_address); end
    n_cmp++; if (mem_data !== 16'hAABB) begin n_err++; $display("FAIL pair_data: got %h expected aabb", mem_data); end
    n_cmp++; if (mem_be !== 2'b11) begin n_err++; $display("FAIL pair_be: got %b expected 11", mem_be); end
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    n_cmp++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL pair_done: got req=%b busy=%b expected 0 0", mem_req, busy); end
  endtask

  task automatic test_lone_odd();
    drive(1'b1, 32'h203, 8'h5C, 1'b0);
    for (int i = 1; i <= FLUSH; i++) begin
      drive(1'b0, 32'h0, 8'h00, 1'b0);
      if (i < FLUSH) begin
        n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL lone_early_req cycle %0d: got %b expected 0", i, mem_req); end
      end else begin
        n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL lone_req: got %b expected 1", mem_req); end
        n_cmp++; if (mem_address !== 24'h101) begin n_err++; $display("FAIL lone_addr: got %h expected 000101", mem_address); end
        n_cmp++; if (mem_data[7:0] !== 8'h5C) begin n_err++; $display("FAIL lone_data: got %h expected 5c", mem_data[7:0]); end
        n_cmp++; if (mem_be !== 2'b01) begin n_err++; $display("FAIL lone_be: got %b expected 01", mem_be); end
      end
    end
    drive(1'b0, 32'h0, 8'h00, 1'b1);
  endtask

  task automatic test_word_change();
    drive(1'b1, 32'h10, 8'h11, 1'b0);
    drive(1'b1, 32'h20, 8'h22, 1'b0);
    n_cmp++; if (mem_req !== 1'b1 || mem_address !== 24'h08) begin n_err++; $display("FAIL chg_first_addr: got req=%b addr=%h expected 1 000008", mem_req, mem_address); end
    n_cmp++; if (mem_be !== 2'b10 || mem_data[15:8] !== 8'h11) begin n_err++; $display("FAIL chg_first_word: got be=%b data=%h expected 10 11xx", mem_be, mem_data); end
    repeat (FLUSH) drive(1'b0, 32'h0, 8'h00, 1'b0);
    n_cmp++; if (mem_address !== 24'h08 || busy !== 1'b1) begin n_err++; $display("FAIL chg_stable: got addr=%h busy=%b expected 000008 1", mem_address, busy); end
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    n_cmp++; if (mem_req !== 1'b1 || mem_address !== 24'h10) begin n_err++; $display("FAIL chg_second_addr: got req=%b addr=%h expected 1 000010", mem_req, mem_address); end
    n_cmp++; if (mem_be !== 2'b10 || mem_data[15:8] !== 8'h22) begin n_err++; $display("FAIL chg_second_word: got be=%b data=%h expected 10 22xx", mem_be, mem_data); end
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL chg_drained: got %b expected 0", mem_req); end
  endtask

  task automatic test_overwrite();
    drive(1'b1, 32'h30, 8'h01, 1'b0);
    drive(1'b1, 32'h30, 8'h02, 1'b0);
    n_cmp++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL ovw_no_push: got %b expected 0", mem_req); end
    drive(1'b1, 32'h31, 8'h03, 1'b0);
    n_cmp++; if (mem_req !== 1'b1 || mem_address !== 24'h18) begin n_err++; $display("FAIL ovw_addr: got req=%b addr=%h expected 1 000018", mem_req, mem_address); end
    n_cmp++; if (mem_data !== 16'h0203 || mem_be !== 2'b11) begin n_err++; $display("FAIL ovw_word: got data=%h be=%b expected 0203 11", mem_data, mem_be); end
    drive(1'b0, 32'h0, 8'h00, 1'b1);
    n_cmp++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL ovw_single: got req=%b busy=%b expected 0 0", mem_req, busy); end
  endtask

  task automatic test_overflow();
    logic [7:0] ev, od;
    for (int i = 0; i < 10; i++) drive(1'b1, 32'(i), 8'(8'h40 + i), 1'b0);
    n_cmp++; if (overflow !== 1'b1 || mem_req !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got ovf=%b req=%b expected 1 1", overflow, mem_req); end
    for (int k = 0; k < DEPTH; k++) begin
      ev = 8'(8'h40 + 2 * k);
      od = 8'(8'h41 + 2 * k);
      n_cmp++;
      if (mem_req !== 1'b1 || mem_address !== 24'(k) || mem_data !== {ev, od} || mem_be !== 2'b11) begin
        n_err++;
        $display("FAIL ovf_word%0d: got req=%b addr=%h data=%h be=%b expected 1 %h %h 11", k, mem_req, mem_address, mem_data, mem_be, 24'(k), {ev, od});
      end
      drive(1'b0, 32'h0, 8'h00, 1'b1);
    end
    n_cmp++; if (mem_req !== 1'b0 || busy !== 1'b0 || overflow !== 1'b1) begin n_err++; $display("FAIL ovf_end: got req=%b busy=%b ovf=%b expected 0 0 1", mem_req, busy, overflow); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic        wr, ack;
    exp_t        h;
    for (int c = 0; c < 400; c++) begin
      wr  = ($urandom_range(0, 99) < 60);
      ack = ($urandom_range(0, 99) < 40);
      a   = 32'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a = a | ($urandom & 32'hFFFF_FFF0);
      drive(wr, a, 8'($urandom), ack);
      n_cmp++;
      if (mem_req !== (m_q.size() != 0) || busy !== (m_hold || m_q.size() != 0) || overflow !== m_ovf) begin
        n_err++;
        $display("FAIL rnd_ctrl cycle %0d: got req=%b busy=%b ovf=%b expected %b %b %b", c, mem_req, busy, overflow, m_q.size() != 0, m_hold || m_q.size() != 0, m_ovf);
      end
      if (m_q.size() != 0) begin
        h = m_q[0];
        n_cmp++;
        if (mem_address !== h.addr || mem_data !== h.data || mem_be !== h.be) begin
          n_err++;
          $display("FAIL rnd_head cycle %0d: got %h/%h/%b expected %h/%h/%b", c, mem_address, mem_data, mem_be, h.addr, h.data, h.be);
        end
      end
    end
    repeat (12) drive(1'b0, 32'h0, 8'h00, 1'b1);
    n_cmp++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rnd_drain: got req=%b busy=%b expected 0 0", mem_req, busy); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 6; i++) drive(1'b1, 32'(32'h300 + i), 8'(i), 1'b0);
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL mid_pre_req: got %b expected 1", mem_req); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (mem_req !== 1'b0 || mem_address !== 24'h0 || mem_data !== 16'h0 || mem_be !== 2'b00 || busy !== 1'b0 || overflow !== 1'b0) begin
      n_err++;
      $display("FAIL mid_async: got req=%b addr=%h data=%h be=%b busy=%b ovf=%b expected all 0", mem_req, mem_address, mem_data, mem_be, busy, overflow);
    end
    m_reset();
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0, 8'h00, 1'(i % 2));
      n_cmp++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL mid_after cycle %0d: got req=%b busy=%b expected 0 0", i, mem_req, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_lone_odd();
    test_word_change();
    test_overwrite();
    test_overflow();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/byte_write_packer.md
# byte_write_packer

Write-side stage directly downstream of the bridge byte serialiser: it consumes the one-byte-per-cycle write stream (byte address, byte data, write strobe) and packs it into 16-bit word writes with byte enables. Packed words pass through a small FIFO to a slower 16-bit memory port (SRAM/PSRAM controller) that uses a req/ack handshake. The block is write-only; loader reads do not pass through it.

## Interface
Parameters:
- `ADDR_W`, default 24: width of the word address presented to memory; `mem_address = byte_address[ADDR_W:1]`, and upper bits are ignored.
- `FIFO_DEPTH`, default 4: number of packed-word entries; must be a power of two and ≥ 2.
- `FLUSH_CYCLES`, default 4: idle cycles after which a partially filled word is flushed; range 1..255.

Ports:
- `clk` in 1: the single clock. All logic is on its rising edge.
- `reset_n` in 1: reset, asynchronous and active-low.
- `byte_address` in 32: byte address, sampled when `byte_wr` is high.
- `byte_data` in 8: write data, sampled when `byte_wr` is high.
- `byte_wr` in 1: single-cycle write strobe. One byte per cycle, at most.
- `mem_address` out ADDR_W: word address of the presented entry.
- `mem_data` out 16: word data. The even byte is in [15:8] and the odd byte is in [7:0] (big-endian lanes).
- `mem_be` out 2: byte enables. `[1]` is the even (upper) lane; `[0]` is the odd (lower) lane.
- `mem_req` out 1: an entry is presented.
- `mem_ack` in 1: memory accepts the entry on this edge.
- `busy` out 1: `assembly != EMPTY || fifo_count != 0`.
- `overflow` out 1: sticky; set when a push is dropped. Cleared only by reset.

## Operation
- The assembly register holds one partial word: word address, 16-bit data, 2-bit lane mask.
- The assembly register has two states, EMPTY and HOLD.
- EMPTY + `byte_wr`: load the byte into its lane (lane = `byte_address[0]`), set that lane bit, go to HOLD, clear the idle counter.
- HOLD + `byte_wr` to the same word, other lane: push the merged word with `be=2'b11`, go to EMPTY.
- HOLD + `byte_wr` to the same word, same lane: overwrite that lane's data, no push, clear the idle counter.
- HOLD + `byte_wr` to a different word: push the held word with its current mask, load the new byte as from EMPTY, stay in HOLD.
- HOLD with no `byte_wr`: the idle counter increments. When it reaches FLUSH_CYCLES, push the held word with its mask and go to EMPTY.
- At most one push per cycle, by construction.
- Full-FIFO push: if the FIFO is full and there is no pop on the same edge, the entry is dropped and `overflow` is set. The assembly state still transitions as above.
- Push and pop on the same edge while full: the push is accepted and the count is unchanged.
- FIFO pop happens on an edge where `mem_req && mem_ack`.
- Output fields are the FIFO head (show-ahead). They are stable while `mem_req` is high and not acked.

## Timing
- Reset: `mem_req`, `mem_address`, `mem_data`, `mem_be`, `busy` and `overflow` are all 0. The FIFO is empty, the assembly is EMPTY and the idle counter is 0.
- Reset asserted mid-operation: `mem_req` drops asynchronously. Buffered and held data are discarded.
- Latency, completing byte: a byte that completes a word on edge N is pushed at edge N, and `mem_req` is high from the cycle after N.
- Latency, lone byte: written at edge N with no further writes, it is pushed at edge N+FLUSH_CYCLES.
- Handshake: `mem_req` is held until acked. At the ack edge, the next entry (if any) is presented and `mem_req` stays high, giving back-to-back transfers at one word per cycle when `mem_ack` is held high.
- `mem_ack` while `mem_req` is low is ignored.
- A write that arrives on the same edge as an idle flush takes priority over the flush; the transition rules above apply.
- FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. The count is log2(FIFO_DEPTH)+1 bits.

## Structure
- Package `byte_packer_pkg` holds:
  - typedef `packed_word_t`, a struct of `{logic [ADDR_W-1:0] addr; logic [15:0] data; logic [1:0] be;}` (width via package parameter default 24);
  - enum `assembly_state_t {EMPTY, HOLD}`.
- Sub-module `packed_word_fifo`: synchronous show-ahead FIFO of `packed_word_t` with push, pop, full, empty and count.
- The top level contains the assembly state machine, the idle counter and the overflow flag.

## Test plan
- **Sequential pair, hold ack:** bytes to 0x100 (0xAA) and 0x101 (0xBB) on consecutive cycles, `mem_ack` held high → one request with `mem_address=0x80`, `mem_data=0xAABB`, `mem_be=11`, `mem_req` high in the cycle after the second write.
- **Lone odd byte:** 0x203 = 0x5C, then idle, FLUSH_CYCLES=4 → request with address 0x101, data[7:0]=0x5C, `be=01`, pushed 4 cycles after the write.
- **Word change while holding:** 0x10=0x11, then 0x20=0x22 → first request is address 0x08, `be=10`, data[15:8]=0x11. Then, after the flush, address 0x10, `be=10`, data[15:8]=0x22.
- **Same-lane overwrite:** 0x30=0x01, 0x30=0x02, 0x31=0x03 → a single request with data 0x0203 and `be=11`.
- **Overflow, ack held low:** FIFO_DEPTH=4, 10 sequential bytes from 0x0 → 4 entries accepted and `overflow=1`. Releasing ack yields exactly words 0..3 in order, and `busy` falls after the last ack.
- **Reset mid-transfer:** assert `reset_n` low while `mem_req` is high with 3 entries queued → all outputs 0 immediately. After release, no request appears without new writes.
